// File: rtl/imm_encoder_pkg.sv
// Shared RV32I immediate type codes, opcode constants and the encode/decode
// helpers used by the immediate encoder and its optional round-trip checker.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        ITYPE = 3'd0,
        STYPE = 3'd1,
        BTYPE = 3'd2,
        UTYPE = 3'd3,
        JTYPE = 3'd4,
        RTYPE = 3'd5
    } imm_type_e;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_OP     = 7'h33;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } enc_t;

    function automatic enc_t imm_encode(input logic [2:0]  ty,
                                        input logic [31:0] imm,
                                        input logic [31:0] base);
        enc_t        r;
        logic        legal;
        logic [31:0] v;
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; in combinational logic a missed path infers a latch.
        r.inst = base;
        legal  = 1'b0;
        case (imm_type_e'(ty))
            ITYPE, STYPE: legal = (&imm[31:11]) | ~(|imm[31:11]);
            BTYPE:        legal = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
            JTYPE:        legal = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
            UTYPE:        legal = ~(|imm[11:0]);
            RTYPE:        legal = 1'b1;
            default:      legal = 1'b0;
        endcase
        // An illegal immediate still emits a word, with its immediate fields zeroed.
        v = legal ? imm : 32'h0;
        case (imm_type_e'(ty))
            ITYPE: r.inst[31:20] = v[11:0];
            STYPE: begin
                r.inst[31:25] = v[11:5];
                r.inst[11:7]  = v[4:0];
            end
            BTYPE: begin
                r.inst[31]    = v[12];
                r.inst[30:25] = v[10:5];
                r.inst[11:8]  = v[4:1];
                r.inst[7]     = v[11];
            end
            UTYPE: r.inst[31:12] = v[31:12];
            JTYPE: begin
                r.inst[31]    = v[20];
                r.inst[30:21] = v[10:1];
                r.inst[20]    = v[11];
                r.inst[19:12] = v[19:12];
            end
            default: r.inst = base;
        endcase
        r.err = ~legal;
        return r;
    endfunction

    // Same sign-extension rules as the core's immediate-extend stage.
    function automatic logic [31:0] imm_decode(input logic [2:0]  ty,
                                               input logic [31:0] inst);
        logic [31:0] d;
        d = 32'h0;
        case (imm_type_e'(ty))
            ITYPE:   d = {{20{inst[31]}}, inst[31:20]};
            STYPE:   d = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            BTYPE:   d = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            UTYPE:   d = {inst[31:12], 12'h000};
            JTYPE:   d = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: d = 32'h0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_encoder_roundtrip_check.sv
// Re-decodes a registered instruction word and flags any difference from the
// immediate it was built from (legal, non-R words only).
module imm_roundtrip_check
    import imm_encoder_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] inst,
    input  logic [31:0] imm,
    input  logic [2:0]  imm_type,
    input  logic        err,
    output logic        mismatch
);

    logic [31:0] decoded;

    always_comb begin
        decoded  = imm_decode(imm_type, inst);
        mismatch = valid && !err && (imm_type != RTYPE) && (decoded != imm);
    end

endmodule

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: checks and scatters an immediate into an instruction
// template, streaming addressed words out. IMM_ENC_ROUNDTRIP_CHECK_EN adds rt_mismatch.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 addr_clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_imm_type,
    input  logic [31:0]          in_imm,
    input  logic [31:0]          in_base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    ,
    output logic                 rt_mismatch
`endif
);

    localparam logic [31:0] ADDR_INC = 32'd4;

    logic        accept;
    enc_t        enc;
    logic [31:0] addr_cnt;
    logic [31:0] word_addr;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign word_addr = addr_clr ? ADDR_BASE : addr_cnt;

    always_comb begin
        enc = imm_encode(in_imm_type, in_imm, in_base);
    end

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    logic [31:0] chk_imm;
    logic [2:0]  chk_type;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= 32'h0;
            out_addr  <= 32'h0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
            addr_cnt  <= ADDR_BASE;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
            chk_imm   <= 32'h0;
            chk_type  <= 3'd0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_inst  <= enc.inst;
            out_err   <= enc.err;
            out_addr  <= word_addr;
            addr_cnt  <= word_addr + ADDR_INC;
            if (enc.err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
            chk_imm   <= in_imm;
            chk_type  <= in_imm_type;
`endif
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (addr_clr) begin
                addr_cnt <= ADDR_BASE;
            end
        end
    end

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    imm_roundtrip_check u_rt_check (
        .valid    (out_valid),
        .inst     (out_inst),
        .imm      (chk_imm),
        .imm_type (chk_type),
        .err      (out_err),
        .mismatch (rt_mismatch)
    );
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: expected words are queued on accept and
// compared when the encoder presents them downstream.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam logic [31:0] ADDR_BASE = 32'h0000_1000;
    localparam int          ERR_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 addr_clr;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_imm_type;
    logic [31:0]          in_imm;
    logic [31:0]          in_base;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [31:0]          out_inst;
    logic [31:0]          out_addr;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_cnt;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    logic                 rt_mismatch;
`endif

    imm_encoder #(.ADDR_BASE(ADDR_BASE), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_clr    (addr_clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_imm_type (in_imm_type),
        .in_imm      (in_imm),
        .in_base     (in_base),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_addr    (out_addr),
        .out_err     (out_err),
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
        .rt_mismatch (rt_mismatch),
`endif
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_cnt;
    logic [31:0] m_last_addr;
    int          m_errs;
    int          stall_cycles = 0;
    bit          rdy_default = 1'b1;
    bit          rdy_rand = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference encoder written from the field tables and signed ranges.
    task automatic ref_enc(input logic [2:0] ty, input logic [31:0] imm, input logic [31:0] base,
                           output logic [31:0] inst, output logic err);
        int          s;
        bit          ok;
        logic [31:0] v;
        s    = $signed(imm);
        inst = base;
        case (ty)
            ITYPE, STYPE: ok = (s >= -2048) && (s <= 2047);
            BTYPE:        ok = !imm[0] && (s >= -4096) && (s <= 4095);
            JTYPE:        ok = !imm[0] && (s >= -(1 << 20)) && (s <= (1 << 20) - 1);
            UTYPE:        ok = (imm[11:0] == 12'h000);
            RTYPE:        ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        v = ok ? imm : 32'h0;
        case (ty)
            ITYPE: for (int i = 0; i < 12; i++) inst[20+i] = v[i];
            STYPE: begin
                for (int i = 0; i < 5; i++) inst[7+i] = v[i];
                for (int i = 5; i < 12; i++) inst[20+i] = v[i];
            end
            BTYPE: begin
                inst[31] = v[12];
                inst[7]  = v[11];
                for (int i = 1; i < 5; i++) inst[7+i] = v[i];
                for (int i = 5; i < 11; i++) inst[20+i] = v[i];
            end
            UTYPE: for (int i = 12; i < 32; i++) inst[i] = v[i];
            JTYPE: begin
                inst[31] = v[20];
                inst[20] = v[11];
                for (int i = 1; i < 11; i++) inst[20+i] = v[i];
                for (int i = 12; i < 20; i++) inst[i] = v[i];
            end
            default: inst = base;
        endcase
        err = !ok;
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic err, input logic clr);
        exp_t e;
        e.addr      = clr ? ADDR_BASE : m_cnt;
        m_cnt       = e.addr + 32'd4;
        m_last_addr = e.addr;
        e.inst      = inst;
        e.err       = err;
        if (err && m_errs < 255) m_errs++;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [2:0] ty, input logic [31:0] imm, input logic [31:0] base,
                         input logic clr, input logic [31:0] exp_inst, input logic exp_err);
        logic rdy;
        bit   done;
        done        = 1'b0;
        in_valid    = 1'b1;
        in_imm_type = ty;
        in_imm      = imm;
        in_base     = base;
        addr_clr    = clr;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                push_exp(exp_inst, exp_err, clr);
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
        addr_clr = 1'b0;
    endtask

    task automatic send(input logic [2:0] ty, input logic [31:0] imm, input logic [31:0] base,
                        input logic clr);
        logic [31:0] ei;
        logic        ee;
        ref_enc(ty, imm, base, ei, ee);
        drive(ty, imm, base, clr, ei, ee);
    endtask

    task automatic send_known(input logic [2:0] ty, input logic [31:0] imm, input logic [31:0] base,
                              input logic [31:0] exp_inst, input logic exp_err);
        drive(ty, imm, base, 1'b0, exp_inst, exp_err);
    endtask

    task automatic send_random();
        logic [2:0]  ty;
        logic [31:0] imm;
        ty = 3'($urandom_range(0, 5));
        case (ty)
            ITYPE, STYPE: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            BTYPE:        imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            JTYPE:        imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
            UTYPE:        imm = $urandom & 32'hFFFF_F000;
            default:      imm = $urandom;
        endcase
        if ($urandom_range(0, 7) == 0) begin
            ty  = 3'($urandom_range(0, 7));
            imm = $urandom;
        end
        send(ty, imm, $urandom, 1'b0);
    endtask

    // Downstream ready: forced stalls, a fixed level, or random backpressure.
    always @(posedge clk) begin
        #1;
        if (stall_cycles > 0) begin
            out_ready = 1'b0;
            stall_cycles--;
        end else if (rdy_rand) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = rdy_default;
        end
    end

    // Output monitor: compare the presented word with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                check("out_inst", out_inst, sb[0].inst);
                check("out_addr", out_addr, sb[0].addr);
                check("out_err", 32'(out_err), 32'(sb[0].err));
                check("err_cnt", 32'(err_cnt), 32'(m_errs));
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
                check("rt_mismatch", 32'(rt_mismatch), 32'd0);
`endif
                if (!out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
                else            void'(sb.pop_front());
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        addr_clr    = 1'b0;
        in_valid    = 1'b0;
        in_imm_type = 3'd0;
        in_imm      = 32'h0;
        in_base     = 32'h0;
        m_cnt       = ADDR_BASE;
        m_last_addr = 32'h0;
        m_errs      = 0;

        #22;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known vectors, first one lands on ADDR_BASE.
        send_known(ITYPE, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        send_known(BTYPE, 32'd8,         32'h0000_0063, 32'h0000_0463, 1'b0);
        send_known(JTYPE, 32'hFFFF_FFFC, 32'h0000_006F, 32'hFFDF_F06F, 1'b0);
        send_known(UTYPE, 32'h1234_5000, 32'h0000_00B7, 32'h1234_50B7, 1'b0);
        send_known(BTYPE, 32'd6,         32'h0000_0063, 32'h0000_0363, 1'b0);
        send_known(RTYPE, 32'hDEAD_BEEF, 32'h00B5_0533, 32'h00B5_0533, 1'b0);
        send_known(STYPE, 32'hFFFF_F800, {25'h0, OPC_STORE}, 32'h8000_0023, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("err_cnt_0", 32'(err_cnt), 32'd0);

        // Illegal immediates: fields forced to zero, error counted on accept.
        send_known(ITYPE, 32'd2048, 32'hFFF0_0013, 32'h0000_0013, 1'b1);
        check("err_cnt_1", 32'(err_cnt), 32'd1);
        send_known(BTYPE, 32'd7, 32'hFE00_0FE3, 32'h0000_0063, 1'b1);
        check("err_cnt_2", 32'(err_cnt), 32'd2);
        send_known(STYPE, 32'd4096, 32'hFE00_0FA3, 32'h0000_0023, 1'b1);
        send_known(UTYPE, 32'h1234_5001, 32'hFFFF_F0B7, 32'h0000_00B7, 1'b1);
        send_known(JTYPE, 32'd3, 32'hFFFF_F06F, 32'h0000_006F, 1'b1);
        send_known(3'd6, 32'd0, 32'h1234_5678, 32'h1234_5678, 1'b1);

        for (int i = 0; i < 300; i++) send(ITYPE, 32'h0001_0000, {25'h0, OPC_OP_IMM}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        // addr_clr alone: counter back to base, out_addr untouched.
        addr_clr = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        m_cnt    = ADDR_BASE;
        check("addr_hold_on_clr", out_addr, m_last_addr);

        // Back-to-back stream with a mid-stream stall, then clear on accept.
        send(ITYPE, 32'd1, {25'h0, OPC_OP_IMM}, 1'b0);
        send(STYPE, 32'd2, {25'h0, OPC_STORE}, 1'b0);
        stall_cycles = 3;
        send(BTYPE, 32'd4, {25'h0, OPC_BRANCH}, 1'b0);
        send(JTYPE, 32'd8, {25'h0, OPC_JAL}, 1'b0);
        send(UTYPE, 32'h0000_1000, {25'h0, OPC_LUI}, 1'b1);
        send(RTYPE, 32'd0, {25'h0, OPC_OP}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("addr_after_clr", out_addr, ADDR_BASE + 32'd4);

        // Reset in the middle of a stall drops the held word.
        rdy_default = 1'b0;
        @(posedge clk);
        #1;
        send(ITYPE, 32'd5, {25'h0, OPC_OP_IMM}, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_addr", out_addr, 32'h0);
        check("midrst_out_inst", out_inst, 32'h0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        sb.delete();
        m_cnt       = ADDR_BASE;
        m_errs      = 0;
        m_last_addr = 32'h0;
        #5;
        @(negedge clk);
        rst_n       = 1'b1;
        rdy_default = 1'b1;
        @(posedge clk);
        #1;
        send(ITYPE, 32'd9, {25'h0, OPC_OP_IMM}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_addr", out_addr, ADDR_BASE);

        // Random mix under random backpressure.
        rdy_rand = 1'b1;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
        for (int i = 0; i < 10000; i++) send_random();
`else
        for (int i = 0; i < 1500; i++) send_random();
`endif
        rdy_rand    = 1'b0;
        rdy_default = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
